// File: rtl/fixed_to_float_seq_pkg.sv
// Shared definitions for the sequential fixed-point to IEEE-754 single-precision
// converter: controller state encoding and float field widths/bias.
package fixed_to_float_seq_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StNorm = 3'd2,
        StPack = 3'd3,
        StDone = 3'd4
    } state_e;

    localparam int unsigned ExpBias  = 127;
    localparam int unsigned ExpWidth = 8;
    localparam int unsigned ManWidth = 23;
    localparam int unsigned LzWidth  = 6;

endpackage

// File: rtl/fixed_to_float_seq_norm_shift_count.sv
// Normalizing shifter with leading-zero counter.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset, clears magnitude and count
//   load      - capture |fixed| into the magnitude register and clear the count
//   fixed     - two's-complement input value
//   shift_en  - shift the magnitude left by one and count, unless already normalized
//   mag       - current magnitude
//   lz        - number of shifts performed since load
//   norm_done - magnitude MSB is set (normalized)
module norm_shift_count
    import fixed_to_float_seq_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [W-1:0]       fixed,
    input  logic               shift_en,
    output logic [W-1:0]       mag,
    output logic [LzWidth-1:0] lz,
    output logic               norm_done
);

    logic [W-1:0]       mag_q;
    logic [LzWidth-1:0] lz_q;
    logic [W-1:0]       fixed_abs;

    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no special case is needed.
    always_comb begin
        fixed_abs = fixed;
        if (fixed[W-1]) begin
            fixed_abs = ~fixed + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q <= '0;
            lz_q  <= '0;
        end else if (load) begin
            mag_q <= fixed_abs;
            lz_q  <= '0;
        end else if (shift_en && !mag_q[W-1]) begin
            mag_q <= {mag_q[W-2:0], 1'b0};
            lz_q  <= lz_q + {{(LzWidth-1){1'b0}}, 1'b1};
        end
    end

    assign mag       = mag_q;
    assign lz        = lz_q;
    assign norm_done = mag_q[W-1];

endmodule

// File: rtl/fixed_to_float_seq.sv
// Sequential two's-complement fixed-point to IEEE-754 single-precision converter.
// One left shift per cycle normalizes the magnitude; the mantissa is truncated.
// Ports:
//   CLK          - clock, rising edge
//   RST_FF       - asynchronous active-high reset
//   Begin_FSM_FF - start request, level-sensitive, sampled only while idle
//   FIXED        - fixed-point input with FRAC_BITS fractional bits, captured in LOAD
//   ACK_FF       - one-cycle pulse, RESULT valid from this cycle
//   BUSY         - high whenever a conversion is in progress
//   RESULT       - packed float, held until overwritten by the next conversion
module fixed_to_float_seq
    import fixed_to_float_seq_pkg::*;
#(
    parameter int unsigned W         = 32,
    parameter int unsigned FRAC_BITS = 26
) (
    input  logic         CLK,
    input  logic         RST_FF,
    input  logic         Begin_FSM_FF,
    input  logic [W-1:0] FIXED,
    output logic         ACK_FF,
    output logic         BUSY,
    output logic [W-1:0] RESULT
);

    localparam int unsigned ExpOffset = ExpBias + W - 1 - FRAC_BITS;

    state_e             state_q, state_d;
    logic [W-1:0]       result_q, result_d;
    logic               sign_q, sign_d;
    logic               pack_wait_q, pack_wait_d;

    logic               load;
    logic               shift_en;
    logic [W-1:0]       mag;
    logic [LzWidth-1:0] lz;
    logic               norm_done;

    logic [9:0]         exp_wide;
    logic [31:0]        packed_float;

    norm_shift_count #(
        .W (W)
    ) u_norm (
        .clk       (CLK),
        .rst       (RST_FF),
        .load      (load),
        .fixed     (FIXED),
        .shift_en  (shift_en),
        .mag       (mag),
        .lz        (lz),
        .norm_done (norm_done)
    );

    always_comb begin
        exp_wide     = 10'(ExpOffset) - {{(10-LzWidth){1'b0}}, lz};
        packed_float = {sign_q, exp_wide[ExpWidth-1:0], mag[W-2 -: ManWidth]};
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        sign_d      = sign_q;
        pack_wait_d = pack_wait_q;
        load        = 1'b0;
        shift_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Begin_FSM_FF) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                load   = 1'b1;
                sign_d = FIXED[W-1];
                if (FIXED == '0) begin
                    // Zero skips NORM; one PACK wait cycle keeps its latency
                    // equal to that of an already-normalized input.
                    pack_wait_d = 1'b1;
                    state_d     = StPack;
                end else begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (norm_done) begin
                    state_d = StPack;
                end else begin
                    shift_en = 1'b1;
                end
            end
            StPack: begin
                if (pack_wait_q) begin
                    pack_wait_d = 1'b0;
                end else begin
                    state_d = StDone;
                    if (mag == '0) begin
                        result_d = '0;
                    end else begin
                        result_d = W'(packed_float);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST_FF) begin
        if (RST_FF) begin
            state_q     <= StIdle;
            result_q    <= '0;
            sign_q      <= 1'b0;
            pack_wait_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            sign_q      <= sign_d;
            pack_wait_q <= pack_wait_d;
        end
    end

    assign ACK_FF = (state_q == StDone);
    assign BUSY   = (state_q != StIdle);
    assign RESULT = result_q;

endmodule

// File: doc/fixed_to_float_seq.md
FIXED_TO_FLOAT_SEQ -- requirements
Module: fixed_to_float_seq

Interface
REQ-001 SHALL have parameter W, default 32: fixed-point input and float result width.
REQ-002 SHALL have parameter FRAC_BITS, default 26: fractional bits of the two's-complement fixed input.
REQ-003 SHALL have port CLK, input, 1: system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_FF, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port Begin_FSM_FF, input, 1: start request, sampled only in IDLE.
REQ-006 SHALL have port FIXED, input, W: two's-complement fixed value, captured in LOAD.
REQ-007 SHALL have port ACK_FF, output, 1: one-cycle pulse; RESULT is valid from this cycle.
REQ-008 SHALL have port BUSY, output, 1: high in every state except IDLE.
REQ-009 SHALL have port RESULT, output, W: IEEE-754 single-precision result, held until the next LOAD.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, NORM, PACK, DONE.
REQ-011 IDLE -> LOAD when Begin_FSM_FF=1; otherwise stays in IDLE.
REQ-012 LOAD: SHALL register sign=FIXED[W-1], MAG=|FIXED| (unsigned W bits), LZ=0.
REQ-013 LOAD: MAG==0 -> PACK; otherwise -> NORM.
REQ-014 NORM: if MAG[W-1]==1 -> PACK; else MAG<<=1, LZ+=1, stay in NORM; one shift per cycle.
REQ-015 PACK: SHALL form RESULT = {sign, EXP[7:0], MAG[W-2:W-24]}, where EXP = 127 + (W-1-FRAC_BITS) - LZ.
REQ-016 PACK with MAG==0: RESULT SHALL be 0x00000000 (sign forced 0); then -> DONE.
REQ-017 DONE: ACK_FF=1 for exactly this cycle; -> IDLE unconditionally.
REQ-018 Mantissa SHALL be truncated (no rounding); denormals never occur for default parameters.
REQ-019 FIXED = 0x80000000 SHALL convert correctly: MAG=0x80000000, LZ=0.
REQ-020 Latency: ACK_FF SHALL be high in the cycle after rising edge 3+LZ, counted from the edge that samples Begin_FSM_FF (edge 0); zero input uses 3.
REQ-021 Begin_FSM_FF SHALL be ignored while BUSY=1.
REQ-022 Begin_FSM_FF still high in the cycle after DONE SHALL start a new conversion (level-sensitive in IDLE).
REQ-023 FIXED changes after LOAD SHALL NOT affect the conversion in progress.
REQ-024 LZ counter SHALL be 6 bits wide; LZ never exceeds W-1.

Reset
REQ-025 RST_FF=1 SHALL immediately force state IDLE, ACK_FF=0, BUSY=0, RESULT=0, MAG=0, LZ=0, sign=0.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion with no ACK_FF pulse.
REQ-027 After reset deassertion, the first Begin_FSM_FF SHALL behave as from power-up.

Structure
REQ-028 The shared package/include SHALL hold the state encodings, the bias constant 127, and the 8/23 exponent/mantissa widths.
REQ-029 The normalizing shifter+counter (MAG, LZ, done flag) SHALL be one sub-module, norm_shift_count; the FSM and packing logic SHALL stay in the top.
REQ-030 The FSM SHALL use registered outputs; there SHALL be no combinational path from FIXED to RESULT.

Verification
REQ-031 FIXED=0x04000000 (1.0) with a Begin pulse -> RESULT=0x3F800000; ACK_FF after edge 8 (LZ=5).
REQ-032 FIXED=0xFE000000 (-0.5) -> RESULT=0xBF000000, LZ=6; FIXED=0x80000000 -> RESULT=0xC2000000, ACK_FF after edge 3.
REQ-033 FIXED=0x00000000 -> RESULT=0x00000000; ACK_FF after edge 3; NORM is never entered.
REQ-034 FIXED=0x00000001 -> RESULT=0x32800000 (2^-26, LZ=31); ACK_FF after edge 34; a Begin pulse mid-conversion is ignored.
REQ-035 RST_FF asserted during NORM of a long conversion -> outputs zero immediately, no ACK_FF; the next conversion is correct.
REQ-036 Begin_FSM_FF held high continuously -> back-to-back conversions, one ACK_FF per conversion, each RESULT matching the FIXED value present at its LOAD.
